// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//   Data-memory access sequencer between the MEM stage and a req/ack data bus.
//   Each load/store freezes the pipeline, runs one bus transaction with
//   byte-lane steering and a timeout, then returns extended load data or a
//   fault cause to writeback.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_valid/read/write       MEM-stage access request
//   mem_funct3                 RISC-V load/store size + signedness
//   mem_addr, mem_wdata        byte address, store data (low bits used)
//   stall                      freeze IF..MEM (combinational)
//   done, fault                one-cycle completion / failure pulses
//   rdata                      extended load data (registered)
//   fault_cause                00 ok, 01 illegal, 10 bus error, 11 timeout
//   bus_req/we/addr/wdata/be   bus request fields (registered, held stable)
//   bus_ack, bus_err, bus_rdata  bus response
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] CAUSE_OK      = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // Counter holds completed REQ cycles; the last allowed REQ cycle is the
  // one where it equals TIMEOUT-1, so bus_req stays high exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  cause_nx;
  logic [7:0]  to_cnt;
  logic        access, illegal;
  logic        ld_op;          // latched: current transaction is a load
  logic [2:0]  ld_funct3;      // latched load size/sign for extension
  logic [1:0]  ld_off;         // latched byte offset for lane selection
  logic [31:0] ld_ext;

  // funct3[1:0]: 00 byte, 01 half, 10 word; funct3[2] marks unsigned loads.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (rd) begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = off[0];
        3'b010:         bad = |off;
        default:        bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = off[0];
        3'b010:  bad = |off;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    b   = word[8*off +: 8];
    h   = off[1] ? word[31:16] : word[15:0];
    sgn = ~f3[2];
    case (f3[1:0])
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign access  = mem_valid & (mem_read | mem_write);
  assign illegal = is_illegal(mem_read, mem_write, mem_funct3, mem_addr[1:0]);
  assign ld_ext  = load_extend(ld_funct3, ld_off, bus_rdata);

  // Held low during reset so the pipeline is never frozen by a reset FSM.
  assign stall = rst_n & (((state == IDLE) & access) | (state == REQ));

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    cause_nx = fault_cause;
    unique case (state)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            state_nx = DONE;
            cause_nx = CAUSE_ILLEGAL;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        // bus_err has priority over a simultaneous bus_ack.
        if (bus_err) begin
          state_nx = DONE;
          cause_nx = CAUSE_BUS_ERR;
        end else if (bus_ack) begin
          state_nx = DONE;
          cause_nx = CAUSE_OK;
        end else if (to_cnt == TO_LAST) begin
          state_nx = DONE;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      ld_op       <= 1'b0;
      ld_funct3   <= '0;
      ld_off      <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_OK;
      rdata       <= '0;
    end else begin
      bus_req <= (state_nx == REQ);
      done    <= (state_nx == DONE);
      fault   <= (state_nx == DONE) && (cause_nx != CAUSE_OK);

      if (state_nx == DONE) fault_cause <= cause_nx;

      // Capture the request only on acceptance so fields stay stable in REQ.
      if ((state == IDLE) && (state_nx == REQ)) begin
        to_cnt    <= '0;
        bus_we    <= mem_write;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        ld_op     <= mem_read;
        ld_funct3 <= mem_funct3;
        ld_off    <= mem_addr[1:0];
        if (mem_read) begin
          bus_be    <= 4'b1111;
          bus_wdata <= '0;
        end else begin
          case (mem_funct3[1:0])
            2'b00: begin
              bus_be    <= 4'b0001 << mem_addr[1:0];
              bus_wdata <= {4{mem_wdata[7:0]}};
            end
            2'b01: begin
              bus_be    <= mem_addr[1] ? 4'b1100 : 4'b0011;
              bus_wdata <= {2{mem_wdata[15:0]}};
            end
            default: begin
              bus_be    <= 4'b1111;
              bus_wdata <= mem_wdata;
            end
          endcase
        end
      end else if (state == REQ) begin
        to_cnt <= to_cnt + 8'd1;
      end

      // Stores leave rdata untouched; failures clear it.
      if ((state == REQ) && (state_nx == DONE)) begin
        if (cause_nx != CAUSE_OK) rdata <= '0;
        else if (ld_op)           rdata <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed self-checking bench for dmem_access_ctrl (TIMEOUT = 4).
//   Cycle 0 is the cycle an access is presented; inputs change and outputs
//   are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from run_access
  int          obs_req_cnt, obs_done_cyc, obs_stall_cnt;
  logic        obs_fault, obs_we;
  logic [1:0]  obs_cause;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .done(done), .rdata(rdata), .fault(fault),
    .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Presents one access at cycle 0, holds it while stalled, answers the bus
  // with ack/err in the given REQ cycles (0 = never), and records what it saw.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_cyc, input int err_cyc,
                            input logic [31:0] rword);
    obs_req_cnt = 0; obs_done_cyc = -1; obs_stall_cnt = 0;
    obs_fault = 1'b0; obs_cause = 2'b00; obs_rdata = '0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; mem_read = rd; mem_write = wr; mem_funct3 = f3;
    mem_addr = addr; mem_wdata = wd; bus_ack = 1'b0; bus_err = 1'b0;
    bus_rdata = rword;
    #1;
    if (stall) obs_stall_cnt++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (stall) obs_stall_cnt++;
      if (bus_req) begin
        if (obs_req_cnt == 0) begin
          obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_be; obs_we = bus_we;
        end
        obs_req_cnt++;
      end
      if (done) begin
        obs_done_cyc = c; obs_fault = fault; obs_cause = fault_cause; obs_rdata = rdata;
        break;
      end
      bus_ack = (c == ack_cyc);
      bus_err = (c == err_cyc);
    end
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010;
    mem_addr = 32'h100; mem_wdata = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    mem_valid = 1'b0; mem_read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, done, fault, fault_cause, bus_addr, bus_wdata, bus_be, rdata, stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b done=%b fault=%b cause=%b addr=%h wdata=%h be=%b rdata=%h stall=%b expected all 0",
               bus_req, bus_we, done, fault, fault_cause, bus_addr, bus_wdata, bus_be, rdata, stall);
    end
  endtask

  task automatic test_lw_immediate();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, '0, 1, 0, 32'hDEADBEEF);
    n_checks++;
    if ({obs_addr, obs_be, obs_we} !== {32'h100, 4'b1111, 1'b0}) begin
      n_fail++; $display("FAIL lw_bus_fields: addr=%h be=%b we=%b expected 00000100 1111 0", obs_addr, obs_be, obs_we);
    end
    n_checks++;
    if (obs_done_cyc !== 2 || obs_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_done: cycle=%0d rdata=%h expected 2 deadbeef", obs_done_cyc, obs_rdata);
    end
    n_checks++;
    if (obs_stall_cnt !== 2 || obs_req_cnt !== 1 || obs_fault !== 1'b0 || obs_cause !== 2'b00) begin
      n_fail++; $display("FAIL lw_timing: stall=%0d req=%0d fault=%b cause=%b expected 2 1 0 00",
                         obs_stall_cnt, obs_req_cnt, obs_fault, obs_cause);
    end
  endtask

  task automatic test_load_steer();
    run_access(1'b1, 1'b0, 3'b000, 32'h203, '0, 1, 0, 32'h80FF7F01);
    n_checks++;
    if (obs_rdata !== 32'hFFFFFF80) begin
      n_fail++; $display("FAIL lb_0x203: got %h expected ffffff80", obs_rdata);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h203, '0, 1, 0, 32'h80FF7F01);
    n_checks++;
    if (obs_rdata !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu_0x203: got %h expected 00000080", obs_rdata);
    end
    run_access(1'b1, 1'b0, 3'b001, 32'h202, '0, 1, 0, 32'h80FF7F01);
    n_checks++;
    if (obs_rdata !== 32'hFFFF80FF) begin
      n_fail++; $display("FAIL lh_0x202: got %h expected ffff80ff", obs_rdata);
    end
    // Ack arrives in the second REQ cycle: done one cycle later.
    run_access(1'b1, 1'b0, 3'b101, 32'h200, '0, 2, 0, 32'h80FF7F01);
    n_checks++;
    if (obs_rdata !== 32'h00007F01 || obs_done_cyc !== 3 || obs_req_cnt !== 2) begin
      n_fail++; $display("FAIL lhu_0x200_late_ack: rdata=%h done=%0d req=%0d expected 00007f01 3 2",
                         obs_rdata, obs_done_cyc, obs_req_cnt);
    end
  endtask

  task automatic test_store_steer();
    run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h12345678, 1, 0, 32'hFFFFFFFF);
    n_checks++;
    if ({obs_be, obs_wdata, obs_addr, obs_we} !== {4'b0010, 32'h78787878, 32'h300, 1'b1}) begin
      n_fail++; $display("FAIL sb_0x301: be=%b wdata=%h addr=%h we=%b expected 0010 78787878 00000300 1",
                         obs_be, obs_wdata, obs_addr, obs_we);
    end
    run_access(1'b0, 1'b1, 3'b001, 32'h302, 32'h12345678, 1, 0, 32'hFFFFFFFF);
    n_checks++;
    if ({obs_be, obs_wdata} !== {4'b1100, 32'h56785678}) begin
      n_fail++; $display("FAIL sh_0x302: be=%b wdata=%h expected 1100 56785678", obs_be, obs_wdata);
    end
    run_access(1'b0, 1'b1, 3'b010, 32'h304, 32'h12345678, 1, 0, 32'hFFFFFFFF);
    n_checks++;
    if ({obs_be, obs_wdata, obs_addr} !== {4'b1111, 32'h12345678, 32'h304}) begin
      n_fail++; $display("FAIL sw_0x304: be=%b wdata=%h addr=%h expected 1111 12345678 00000304",
                         obs_be, obs_wdata, obs_addr);
    end
    // Stores leave the last load result in place.
    n_checks++;
    if (obs_rdata !== 32'h00007F01 || obs_cause !== 2'b00) begin
      n_fail++; $display("FAIL store_keeps_rdata: rdata=%h cause=%b expected 00007f01 00", obs_rdata, obs_cause);
    end
  endtask

  task automatic test_illegal();
    logic       rd_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       wr_v [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] f3_v [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad_v [5] = '{32'h102, 32'h101, 32'h100, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      run_access(rd_v[i], wr_v[i], f3_v[i], ad_v[i], 32'hA5A5A5A5, 1, 0, 32'h0);
      n_checks++;
      if (obs_req_cnt !== 0 || obs_done_cyc !== 1 || obs_fault !== 1'b1 ||
          obs_cause !== 2'b01 || obs_stall_cnt !== 1) begin
        n_fail++;
        $display("FAIL illegal_%0d: req=%0d done=%0d fault=%b cause=%b stall=%0d expected 0 1 1 01 1",
                 i, obs_req_cnt, obs_done_cyc, obs_fault, obs_cause, obs_stall_cnt);
      end
    end
    // Illegal accesses do not disturb the held load result.
    n_checks++;
    if (obs_rdata !== 32'h00007F01) begin
      n_fail++; $display("FAIL illegal_keeps_rdata: got %h expected 00007f01", obs_rdata);
    end
  endtask

  task automatic test_ignore_idle_response();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h55555555;
    repeat (3) begin
      @(negedge clk);
      if (done || bus_req) seen_done++;
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    n_checks++;
    if (seen_done !== 0 || rdata !== 32'h00007F01 || fault_cause !== 2'b01) begin
      n_fail++; $display("FAIL idle_ignores_bus: events=%0d rdata=%h cause=%b expected 0 00007f01 01",
                         seen_done, rdata, fault_cause);
    end
  endtask

  task automatic test_bus_err();
    run_access(1'b1, 1'b0, 3'b010, 32'h108, '0, 0, 3, 32'h12121212);
    n_checks++;
    if (obs_req_cnt !== 3 || obs_done_cyc !== 4 || obs_fault !== 1'b1 ||
        obs_cause !== 2'b10 || obs_rdata !== 32'h0) begin
      n_fail++; $display("FAIL bus_err: req=%0d done=%0d fault=%b cause=%b rdata=%h expected 3 4 1 10 00000000",
                         obs_req_cnt, obs_done_cyc, obs_fault, obs_cause, obs_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'b10) begin
      n_fail++; $display("FAIL bus_err_hold: done=%b fault=%b cause=%b expected 0 0 10", done, fault, fault_cause);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h10C, '0, 1, 0, 32'h11223344);
    n_checks++;
    if (obs_rdata !== 32'h11223344) begin
      n_fail++; $display("FAIL pre_timeout_load: got %h expected 11223344", obs_rdata);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h110, '0, 0, 0, 32'h99999999);
    n_checks++;
    if (obs_req_cnt !== 4 || obs_done_cyc !== 5 || obs_stall_cnt !== 5 || obs_fault !== 1'b1 ||
        obs_cause !== 2'b11 || obs_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout: req=%0d done=%0d stall=%0d fault=%b cause=%b rdata=%h expected 4 5 5 1 11 00000000",
                         obs_req_cnt, obs_done_cyc, obs_stall_cnt, obs_fault, obs_cause, obs_rdata);
    end
  endtask

  task automatic test_err_and_ack();
    run_access(1'b1, 1'b0, 3'b010, 32'h114, '0, 1, 0, 32'hCAFEF00D);
    run_access(1'b1, 1'b0, 3'b010, 32'h118, '0, 1, 1, 32'hAAAA5555);
    n_checks++;
    if (obs_done_cyc !== 2 || obs_cause !== 2'b10 || obs_rdata !== 32'h0 || obs_fault !== 1'b1) begin
      n_fail++; $display("FAIL err_wins_over_ack: done=%0d cause=%b rdata=%h fault=%b expected 2 10 00000000 1",
                         obs_done_cyc, obs_cause, obs_rdata, obs_fault);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010;
    mem_addr = 32'h500; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h77777777;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_req_setup: bus_req=%b expected 1", bus_req);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_drop: req=%b done=%b stall=%b expected 0 0 0", bus_req, done, stall);
    end
    @(negedge clk);
    mem_valid = 1'b0; mem_read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, done, fault, fault_cause, bus_addr, bus_wdata, bus_be, rdata, stall} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: req=%b we=%b done=%b fault=%b cause=%b addr=%h wdata=%h be=%b rdata=%h stall=%b expected all 0",
               bus_req, bus_we, done, fault, fault_cause, bus_addr, bus_wdata, bus_be, rdata, stall);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h504, '0, 1, 0, 32'h0BADC0DE);
    n_checks++;
    if (obs_done_cyc !== 2 || obs_rdata !== 32'h0BADC0DE) begin
      n_fail++; $display("FAIL post_reset_access: done=%0d rdata=%h expected 2 0badc0de", obs_done_cyc, obs_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  req_tr, done_tr;
    logic [31:0] addr2, wdata2;
    int          ndone;
    req_tr = '0; done_tr = '0; addr2 = '0; wdata2 = '0; ndone = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_funct3 = 3'b010;
    mem_addr = 32'h400; mem_wdata = 32'hAAAA0001;
    bus_ack = 1'b1; bus_err = 1'b0;   // ack waiting: each REQ completes in one cycle
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_tr[c-1]  = bus_req;
      done_tr[c-1] = done;
      if (c == 4) begin addr2 = bus_addr; wdata2 = bus_wdata; end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          mem_addr = 32'h404; mem_wdata = 32'hBBBB0002;
        end else begin
          mem_valid = 1'b0; mem_write = 1'b0;
        end
      end
    end
    bus_ack = 1'b0;
    // REQ 1, DONE 2, IDLE 3 (second accept), REQ 4, DONE 5.
    n_checks++;
    if (req_tr !== 8'b0000_1001) begin
      n_fail++; $display("FAIL b2b_req_trace: got %b expected 00001001", req_tr);
    end
    n_checks++;
    if (done_tr !== 8'b0001_0010) begin
      n_fail++; $display("FAIL b2b_done_trace: got %b expected 00010010", done_tr);
    end
    n_checks++;
    if (addr2 !== 32'h404 || wdata2 !== 32'hBBBB0002) begin
      n_fail++; $display("FAIL b2b_second_fields: addr=%h wdata=%h expected 00000404 bbbb0002", addr2, wdata2);
    end
  endtask

  initial begin
    test_reset();
    test_lw_immediate();
    test_load_steer();
    test_store_steer();
    test_illegal();
    test_ignore_idle_response();
    test_bus_err();
    test_timeout();
    test_err_and_ack();
    test_reset_mid_req();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
